// File: rtl/input_cond_pkg.sv
// ============================================================================
// Module   : input_cond_pkg
// Purpose  : Shared definitions for the push-button / switch input conditioner.
//            Holds the debounce FSM state type and the default debounce length.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package input_cond_pkg;

    // Default number of consecutive stable synchronized samples needed before
    // a button edge is accepted. 500000 cycles is ~10 ms at 50 MHz, which
    // comfortably outlasts typical mechanical contact bounce.
    localparam int unsigned c_default_debounce_cycles = 500000;

    // Debounce FSM states:
    //   IDLE   - button released and stable
    //   ARM    - button seen pressed, waiting for it to stay pressed
    //   HELD   - press accepted, waiting for release
    //   DISARM - button seen released, waiting for it to stay released
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        HELD   = 2'd2,
        DISARM = 2'd3
    } cond_state_e;

endpackage : input_cond_pkg

`default_nettype wire

// File: rtl/input_conditioner_sync2.sv
// ============================================================================
// Module   : sync2
// Purpose  : Two-flop synchronizer bringing an asynchronous single-bit input
//            into the clk domain. Both flops clear asynchronously on reset.
// Ports    : clk   - system clock, rising edge
//            reset - asynchronous active-low reset
//            d     - asynchronous input
//            q     - synchronized output (two clk edges of latency)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    // First stage may go metastable; it is only ever read by the second stage.
    logic r_meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta <= 1'b0;
            q      <= 1'b0;
        end else begin
            r_meta <= d;
            q      <= r_meta;
        end
    end

endmodule : sync2

`default_nettype wire

// File: rtl/input_conditioner.sv
// ============================================================================
// Module   : input_conditioner
// Purpose  : Turns a raw bouncing push-button into a clean one-cycle "step"
//            enable and captures the data switch value "w" with each step.
//            Both raw inputs are synchronized, the button is debounced by a
//            four-state FSM that demands DEBOUNCE_CYCLES+1 consecutive equal
//            synchronized samples before accepting a press or a release.
// Params   : DEBOUNCE_CYCLES - stable-sample requirement (legal range >= 2)
// Ports    : clk        - system clock, rising edge
//            reset      - asynchronous active-low reset
//            btn_raw    - unsynchronized, bouncing push-button
//            sw_raw     - unsynchronized data switch
//            step       - one-cycle pulse per accepted press
//            w          - switch value captured with each step
//            busy       - high while the FSM is not IDLE
//            step_count - accepted presses, modulo 256
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_default_debounce_cycles
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_raw,
    input  logic       sw_raw,
    output logic       step,
    output logic       w,
    output logic       busy,
    output logic [7:0] step_count
);

    localparam int unsigned c_cnt_w = $clog2(DEBOUNCE_CYCLES + 1);

    // Terminal count: the counter is cleared on entry to ARM/DISARM, so
    // reaching DEBOUNCE_CYCLES-1 while the level persists means that
    // DEBOUNCE_CYCLES samples after the entry sample have agreed.
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Input synchronization
    // ------------------------------------------------------------------
    logic btn_s;
    logic sw_s;

    sync2 u_sync_btn (
        .clk   (clk),
        .reset (reset),
        .d     (btn_raw),
        .q     (btn_s)
    );

    sync2 u_sync_sw (
        .clk   (clk),
        .reset (reset),
        .d     (sw_raw),
        .q     (sw_s)
    );

    // ------------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------------
    cond_state_e              r_state;
    cond_state_e              w_next_state;
    logic [c_cnt_w-1:0]       r_cnt;
    logic [c_cnt_w-1:0]       w_next_cnt;
    logic                     w_accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_accept     = 1'b0;

        case (r_state)
            IDLE: begin
                if (btn_s) begin
                    w_next_state = ARM;
                    w_next_cnt   = '0;
                end
            end

            ARM: begin
                if (!btn_s) begin
                    // Press bounce: abandon without a step.
                    w_next_state = IDLE;
                    w_next_cnt   = '0;
                end else if (r_cnt == c_cnt_last) begin
                    w_next_state = HELD;
                    w_next_cnt   = '0;
                    w_accept     = 1'b1;
                end else begin
                    w_next_cnt = r_cnt + 1'b1;
                end
            end

            HELD: begin
                if (!btn_s) begin
                    w_next_state = DISARM;
                    w_next_cnt   = '0;
                end
            end

            DISARM: begin
                if (btn_s) begin
                    // Release bounce: return to HELD, never re-step.
                    w_next_state = HELD;
                    w_next_cnt   = '0;
                end else if (r_cnt == c_cnt_last) begin
                    w_next_state = IDLE;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt + 1'b1;
                end
            end

            default: begin
                w_next_state = IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    // busy is decoded from the next state so that the flop tracks the state
    // register cycle-for-cycle while still being a pure flop output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step       <= 1'b0;
            w          <= 1'b0;
            busy       <= 1'b0;
            step_count <= 8'd0;
        end else begin
            step <= w_accept;
            busy <= (w_next_state != IDLE);
            if (w_accept) begin
                w          <= sw_s;
                step_count <= step_count + 8'd1;
            end
        end
    end

endmodule : input_conditioner

`default_nettype wire

// File: tb/tb_input_conditioner.sv
// ============================================================================
// Module   : tb_input_conditioner
// Purpose  : Self-checking bench for input_conditioner with DEBOUNCE_CYCLES=4.
//            A reference model derived from run-length rules pushes expected
//            steps into a scoreboard queue; a monitor pops them whenever the
//            DUT pulses step and also checks busy/w/step_count every cycle.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_input_conditioner;

    localparam int DEB = 4;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic       btn_raw = 1'b0;
    logic       sw_raw  = 1'b0;
    logic       step;
    logic       w;
    logic       busy;
    logic [7:0] step_count;

    input_conditioner #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .sw_raw     (sw_raw),
        .step       (step),
        .w          (w),
        .busy       (busy),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a level is accepted once DEB+1 consecutive
    // synchronized samples disagree with the currently accepted level.
    // Synchronized value = raw value sampled two edges earlier.
    // ------------------------------------------------------------------
    typedef struct {
        int         cyc;
        logic       wv;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];

    int         cyc        = 0;
    logic       m_s1       = 1'b0;
    logic       m_s2       = 1'b0;
    logic       m_t1       = 1'b0;
    logic       m_t2       = 1'b0;
    logic       m_b        = 1'b0;
    logic       m_sw       = 1'b0;
    logic       m_accepted = 1'b0;
    int         m_run      = 0;
    logic       m_w        = 1'b0;
    logic       m_busy     = 1'b0;
    logic [7:0] m_count    = 8'd0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_t1 = 1'b0; m_t2 = 1'b0;
            m_accepted = 1'b0; m_run = 0;
            m_w = 1'b0; m_busy = 1'b0; m_count = 8'd0;
        end else begin
            cyc++;
            m_b  = m_s2;
            m_sw = m_t2;
            m_s2 = m_s1; m_s1 = btn_raw;
            m_t2 = m_t1; m_t1 = sw_raw;
            if (m_b != m_accepted) begin
                m_run++;
                if (m_run == DEB + 1) begin
                    m_accepted = m_b;
                    m_run      = 0;
                    if (m_b) begin
                        m_count = m_count + 8'd1;
                        m_w     = m_sw;
                        sb.push_back('{cyc, m_w, m_count});
                    end
                end
            end else begin
                m_run = 0;
            end
            m_busy = m_accepted || (m_run != 0);
        end
    end

    // ------------------------------------------------------------------
    // Monitor: sampled on the falling edge, away from the active edge.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t e;
        if (step === 1'b1) begin
            n_checks++;
            if (sb.size() == 0 || sb[0].cyc != cyc) begin
                n_errors++;
                $display("FAIL step_unexpected: step=1 at cycle %0d, expected step cycle %0d",
                         cyc, (sb.size() == 0) ? -1 : sb[0].cyc);
                if (sb.size() != 0 && sb[0].cyc < cyc) void'(sb.pop_front());
            end else begin
                e = sb.pop_front();
                chk("step_w", w, e.wv);
                chk("step_count_at_step", step_count, e.cnt);
            end
        end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
            n_checks++;
            n_errors++;
            $display("FAIL step_missing: step=%0b at cycle %0d, required 1 at cycle %0d",
                     step, cyc, sb[0].cyc);
            void'(sb.pop_front());
        end
        chk("busy", busy, m_busy);
        chk("w", w, m_w);
        chk("step_count", step_count, m_count);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 2 ns after the rising edge)
    // ------------------------------------------------------------------
    task automatic hold(input logic b, input int n);
        btn_raw = b;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic rhold(input logic b, input int n);
        repeat (n) begin
            btn_raw = b;
            sw_raw  = 1'($urandom_range(0, 1));
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_step(input int bound, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (step === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  n0;
        bit  seen;

        // Reset state
        #3;
        chk("reset_step", step, 0);
        chk("reset_w", w, 0);
        chk("reset_busy", busy, 0);
        chk("reset_count", step_count, 0);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        hold(0, 3);

        // Clean press: step exactly 6 edges after first sampling edge
        sw_raw  = 1'b0;
        btn_raw = 1'b1;
        @(posedge clk);
        #1;
        n0 = cyc;
        wait_step(20, seen);
        chk("clean_step_seen", seen, 1);
        chk("clean_latency", cyc - n0, 6);
        hold(1, 13);
        chk("clean_count", step_count, 1);
        hold(0, 10);
        chk("clean_idle", busy, 0);

        // Press bounce: never accepted
        hold(1, 3);
        hold(0, 1);
        hold(1, 3);
        hold(0, 12);
        chk("bounce_count", step_count, 1);
        chk("bounce_idle", busy, 0);

        // Data capture: w follows switch only at the step edge
        sw_raw = 1'b1;
        hold(1, 7);
        for (int i = 0; i < 10; i++) begin
            sw_raw = ~sw_raw;
            hold(1, 1);
        end
        hold(0, 10);
        chk("capture_w1", w, 1);
        sw_raw = 1'b0;
        hold(1, 7);
        for (int i = 0; i < 10; i++) begin
            sw_raw = ~sw_raw;
            hold(1, 1);
        end
        hold(0, 10);
        chk("capture_w0", w, 0);

        // Release bounce: one step only, ends idle
        sw_raw = 1'b1;
        hold(1, 8);
        hold(0, 2);
        hold(1, 1);
        hold(0, 10);
        chk("release_count", step_count, 4);
        chk("release_idle", busy, 0);
        chk("release_w", w, 1);

        // Reset two cycles into ARM
        hold(1, 4);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("midarm_step", step, 0);
        chk("midarm_w", w, 0);
        chk("midarm_busy", busy, 0);
        chk("midarm_count", step_count, 0);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        n0 = cyc;
        wait_step(20, seen);
        chk("midarm_step_seen", seen, 1);
        chk("midarm_latency", cyc - n0, 6);
        hold(1, 8);
        hold(0, 10);
        chk("midarm_count_after", step_count, 1);

        // Wrap: 256 presses from a fresh reset
        @(negedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        for (int p = 1; p <= 256; p++) begin
            hold(1, 8);
            hold(0, 7);
            if (p == 255) chk("wrap_255", step_count, 255);
            if (p == 256) chk("wrap_0", step_count, 0);
        end

        // Randomized presses, bounces, switch activity and occasional resets
        for (int r = 0; r < 120; r++) begin
            rhold(1'b1, int'($urandom_range(1, 10)));
            rhold(1'b0, int'($urandom_range(1, 10)));
            if ($urandom_range(0, 15) == 0) begin
                @(negedge clk);
                #1;
                reset = 1'b0;
                @(posedge clk);
                #2;
                reset = 1'b1;
            end
        end
        rhold(1'b0, 15);
        chk("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_input_conditioner

`default_nettype wire
